// File: rtl/bus_pkg.sv
// Shared definitions for the bus-side slaves: default widths, controller
// state encoding and the read-return port tag.
package bus_pkg;

  localparam int BUS_ADDR_W = 12;
  localparam int BUS_DATA_W = 8;

  typedef enum logic [1:0] {
    INIT_RST  = 2'd0,
    INIT_WAIT = 2'd1,
    RUN       = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic vld;
    logic port;
  } port_tag_t;

  localparam port_tag_t TAG_NONE = '{vld: 1'b0, port: 1'b0};

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Masked requests are ignored; on a tie the
// input other than the last winner is chosen. Grant is combinational.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] grant
);

  logic       last;
  logic [1:0] elig;

  always_comb begin
    elig  = req & ~mask;
    grant = 2'b00;
    if (en) begin
      if (elig == 2'b11) grant = last ? 2'b01 : 2'b10;
      else               grant = elig;
    end
  end

  // Reset value 1 lets input 0 win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        last <= 1'b1;
    else if (grant[1]) last <= 1'b1;
    else if (grant[0]) last <= 1'b0;
  end

endmodule

// File: rtl/bram_arb_ctrl.sv
// BRAM controller: runs the BRAM reset sequence, then shares the single BRAM
// port between two requesters with round-robin arbitration and tagged reads.
module bram_arb_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int RST_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ready,
  output logic              bram_rsta,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  input  logic [DATA_W-1:0] bram_douta,
  input  logic              bram_rsta_busy
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1) + 1;

  ctrl_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              rsta_nxt;
  logic [1:0]        grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  port_tag_t         issue_tag;
  port_tag_t         rd_pipe [RD_LAT];
  port_tag_t         rd_out;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .req   ({m1_req, m0_req}),
    .mask  ({m1_gnt, m0_gnt}),
    .grant (grant)
  );

  // INIT_WAIT uses cnt as a "one cycle already spent" flag.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rsta_nxt = 1'b0;
    case (state)
      INIT_RST: begin
        if (cnt == CNT_W'(RST_CYCLES)) begin
          state_n = INIT_WAIT;
          cnt_n   = '0;
        end else begin
          rsta_nxt = 1'b1;
          cnt_n    = cnt + CNT_W'(1);
        end
      end
      INIT_WAIT: begin
        if (cnt != '0 && !bram_rsta_busy) state_n = RUN;
        else                              cnt_n   = CNT_W'(1);
      end
      RUN:     state_n = RUN;
      default: state_n = INIT_RST;
    endcase
  end

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (grant[1]) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INIT_RST;
      cnt       <= '0;
      ready     <= 1'b0;
      bram_rsta <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ready     <= (state_n == RUN);
      bram_rsta <= rsta_nxt;
    end
  end

  // Issue stage: grant and BRAM port command leave on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      bram_ena   <= 1'b0;
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
      issue_tag  <= TAG_NONE;
    end else begin
      m0_gnt    <= grant[0];
      m1_gnt    <= grant[1];
      bram_ena  <= |grant;
      bram_wea  <= (|grant) & sel_we;
      issue_tag <= '{vld: (|grant) & ~sel_we, port: grant[1]};
      if (|grant) begin
        bram_addra <= sel_addr;
        bram_dina  <= sel_we ? sel_wdata : '0;
      end
    end
  end

  assign rd_out = rd_pipe[RD_LAT-1];

  // Return stage: the tag tracks the read through the BRAM output latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= TAG_NONE;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      rd_pipe[0] <= issue_tag;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      m0_rvalid <= rd_out.vld & ~rd_out.port;
      m1_rvalid <= rd_out.vld & rd_out.port;
      if (rd_out.vld && !rd_out.port) m0_rdata <= bram_douta;
      if (rd_out.vld &&  rd_out.port) m1_rdata <= bram_douta;
    end
  end

endmodule

// File: tb/tb_bram_arb_ctrl.sv
// Bench for bram_arb_ctrl: BRAM model, transaction-level reference model and
// directed plus randomized two-port traffic.
module tb_bram_arb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [11:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        ready, bram_rsta, bram_ena, bram_wea;
  logic [11:0] bram_addra;
  logic [7:0]  bram_dina, bram_douta;
  logic        bram_rsta_busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  bram_arb_ctrl dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ready(ready), .bram_rsta(bram_rsta), .bram_ena(bram_ena), .bram_wea(bram_wea),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_douta(bram_douta),
    .bram_rsta_busy(bram_rsta_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // BRAM model: two-cycle read, busy held 4 cycles after rsta drops.
  logic [7:0] bram_mem [4096] = '{default: 8'h00};
  logic [7:0] bram_p1 = 8'h00;
  int         busy_cnt = 0;
  initial bram_douta = 8'h00;
  assign bram_rsta_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (bram_rsta) begin
      busy_cnt   <= 4;
      bram_p1    <= 8'h00;
      bram_douta <= 8'h00;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (bram_ena) begin
        if (bram_wea) bram_mem[bram_addra] <= bram_dina;
        else          bram_p1 <= bram_mem[bram_addra];
      end
      bram_douta <= bram_p1;
    end
  end

  // Reference model state
  typedef struct { int port; logic [7:0] data; int due; } rd_t;
  rd_t        rq[$];
  logic [7:0] mem_m [4096] = '{default: 8'h00};
  int         k;
  bit         exp_ready, last_p, pg0, pg1, rdy_prev, e0, e1, g0, g1, ev0, ev1, we_x;
  logic [11:0] a_x, exp_addr;
  logic [7:0]  d_x, exp_din, erd0, erd1;
  logic        r0_s, we0_s, r1_s, we1_s, busy_s;
  logic [11:0] a0_s, a1_s;
  logic [7:0]  d0_s, d1_s;
  longint      t0g, t1g;

  always @(negedge clk) begin
    r0_s = m0_req; we0_s = m0_we; a0_s = m0_addr; d0_s = m0_wdata;
    r1_s = m1_req; we1_s = m1_we; a1_s = m1_addr; d1_s = m1_wdata;
    busy_s = bram_rsta_busy;
  end

  task automatic check_idle(input string p);
    chk({p, "_ready"}, 32'(ready), 32'd0);
    chk({p, "_rsta"},  32'(bram_rsta), 32'd0);
    chk({p, "_gnt0"},  32'(m0_gnt), 32'd0);
    chk({p, "_gnt1"},  32'(m1_gnt), 32'd0);
    chk({p, "_ena"},   32'(bram_ena), 32'd0);
    chk({p, "_wea"},   32'(bram_wea), 32'd0);
    chk({p, "_addra"}, 32'(bram_addra), 32'd0);
    chk({p, "_dina"},  32'(bram_dina), 32'd0);
    chk({p, "_rv0"},   32'(m0_rvalid), 32'd0);
    chk({p, "_rv1"},   32'(m1_rvalid), 32'd0);
    chk({p, "_rd0"},   32'(m0_rdata), 32'd0);
    chk({p, "_rd1"},   32'(m1_rdata), 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      k = 0; exp_ready = 0; last_p = 1; pg0 = 0; pg1 = 0; rq.delete();
      erd0 = '0; erd1 = '0; exp_addr = '0; exp_din = '0;
      check_idle("rst");
    end else begin
      k++;
      rdy_prev = exp_ready;
      e0 = rdy_prev && r0_s && !pg0;
      e1 = rdy_prev && r1_s && !pg1;
      g0 = e0 && !(e1 && last_p == 1'b0);
      g1 = e1 && !(e0 && last_p == 1'b1);
      if (k >= 6 && !busy_s) exp_ready = 1;
      chk("rsta",  32'(bram_rsta), 32'(k >= 1 && k <= 3));
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("gnt0",  32'(m0_gnt), 32'(g0));
      chk("gnt1",  32'(m1_gnt), 32'(g1));
      we_x = 0;
      if (g0 || g1) begin
        we_x = g1 ? we1_s : we0_s;
        a_x  = g1 ? a1_s  : a0_s;
        d_x  = g1 ? d1_s  : d0_s;
        exp_addr = a_x;
        exp_din  = we_x ? d_x : 8'h00;
        last_p   = g1;
        if (we_x) mem_m[a_x] = d_x;
        else      rq.push_back('{port: int'(g1), data: mem_m[a_x], due: k + 3});
      end
      chk("ena",   32'(bram_ena), 32'(g0 || g1));
      chk("wea",   32'(bram_wea), 32'(we_x));
      chk("addra", 32'(bram_addra), 32'(exp_addr));
      chk("dina",  32'(bram_dina), 32'(exp_din));
      pg0 = g0; pg1 = g1;
      ev0 = 0; ev1 = 0;
      if (rq.size() > 0 && rq[0].due == k) begin
        if (rq[0].port == 0) begin ev0 = 1; erd0 = rq[0].data; end
        else                 begin ev1 = 1; erd1 = rq[0].data; end
        void'(rq.pop_front());
      end
      chk("rvalid0", 32'(m0_rvalid), 32'(ev0));
      chk("rvalid1", 32'(m1_rvalid), 32'(ev1));
      chk("rdata0",  32'(m0_rdata), 32'(erd0));
      chk("rdata1",  32'(m1_rdata), 32'(erd1));
    end
  end

  task automatic access(input bit p, input logic we, input logic [11:0] a, input logic [7:0] d);
    bit got = 0;
    if (!p) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else    begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #2;
      got = p ? m1_gnt : m0_gnt;
    end
    if (!p) begin m0_req = 0; t0g = $time; end
    else    begin m1_req = 0; t1g = $time; end
    chk(p ? "gnt1_wait" : "gnt0_wait", 32'(got), 32'd1);
  endtask

  task automatic read_check(input bit p, input logic [11:0] a, input logic [7:0] exp);
    int lat = 0;
    bit seen = 0;
    access(p, 1'b0, a, 8'h00);
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(posedge clk); #2;
      if (p ? m1_rvalid : m0_rvalid) begin seen = 1; lat = i; end
    end
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", 32'(p ? m1_rdata : m0_rdata), 32'(exp));
  endtask

  task automatic wait_ready;
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #2;
      ok = ready;
    end
    chk("ready_wait", 32'(ok), 32'd1);
  endtask

  initial begin
    reset = 0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    repeat (3) @(posedge clk);
    #3 reset = 1;

    // Init with a request held across it, then write/read back
    access(1'b0, 1'b1, 12'h002, 8'hAA);
    chk("ready_at_first_gnt", 32'(ready), 32'd1);
    read_check(1'b0, 12'h002, 8'hAA);
    read_check(1'b1, 12'h002, 8'hAA);

    // Simultaneous write (m0) and read (m1) of one address
    fork
      access(1'b0, 1'b1, 12'h010, 8'h55);
      read_check(1'b1, 12'h010, 8'h55);
    join
    chk("tie_order", 32'(t1g - t0g), 32'd10);

    // Back-to-back from both ports
    fork
      begin
        for (int i = 0; i < 8; i++)
          access(1'b0, 1'(i & 1), 12'(12'h100 + i), 8'($urandom));
      end
      begin
        for (int j = 0; j < 8; j++)
          access(1'b1, 1'((j >> 1) & 1), 12'(12'h100 + j), 8'($urandom));
      end
    join
    repeat (5) @(posedge clk);
    #2;

    // Boundary addresses
    access(1'b0, 1'b1, 12'hFFF, 8'h3C);
    access(1'b0, 1'b1, 12'h000, 8'hC3);
    read_check(1'b0, 12'hFFF, 8'h3C);
    read_check(1'b1, 12'h000, 8'hC3);

    // Random traffic on a small address set to provoke collisions
    fork
      begin
        logic [11:0] ra;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
          ra = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 7)) : 12'(12'hFF8 + $urandom_range(0, 7));
          access(1'b0, 1'($urandom_range(0, 1)), ra, 8'($urandom));
        end
      end
      begin
        logic [11:0] rb;
        for (int j = 0; j < 25; j++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
          rb = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 7)) : 12'(12'hFF8 + $urandom_range(0, 7));
          access(1'b1, 1'($urandom_range(0, 1)), rb, 8'($urandom));
        end
      end
    join
    repeat (6) @(posedge clk);
    #2;

    // Reset one cycle after an m1 read grant
    access(1'b1, 1'b0, 12'h123, 8'h00);
    @(posedge clk);
    #3 reset = 0;
    #1 check_idle("async");
    repeat (3) @(posedge clk);
    #3 reset = 1;
    wait_ready();
    repeat (6) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_arb_ctrl.md
Name: bram_arb_ctrl

Overview:
- Controller and two-port arbiter in front of the single-port 4096x8 block RAM (clka/rsta/ena/wea/addra/dina/douta/rsta_busy).
- Runs the BRAM reset sequence after system reset, then shares the one BRAM port between two bus-side requesters (m0, m1) with round-robin arbitration.
- Pipelines accesses at up to one per cycle and returns read data with a fixed latency per port.
- Sits between the system-bus slave logic and the BRAM instance.

Parameters:
- ADDR_W, 12: BRAM address width (4096 locations).
- DATA_W, 8: data width.
- RD_LAT, 2: cycles from a read on the BRAM port (ena=1, wea=0) to valid douta.
- RST_CYCLES, 3: length of the bram_rsta pulse.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- m0_req / m1_req  in  1  access request; held stable with we/addr/wdata until gnt.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  access address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_gnt / m1_gnt  out  1  one-cycle pulse: request accepted.
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse: read data valid.
- m0_rdata / m1_rdata  out  DATA_W  read data; held until the next rvalid on that port.
- ready  out  1  BRAM initialised; grants possible.
- bram_rsta  out  1  BRAM reset, active high.
- bram_ena, bram_wea  out  1  BRAM enable and write enable.
- bram_addra  out  ADDR_W  BRAM address.
- bram_dina  out  DATA_W  BRAM write data.
- bram_douta  in  DATA_W  BRAM read data.
- bram_rsta_busy  in  1  BRAM reset busy.

Behaviour:
- **Outputs:** all registered.
- **Reset (reset=0):** every output is 0, state=INIT_RST, counter=0, read pipeline cleared, RR pointer=1 (so m0 wins the first tie).

State machine:
- **INIT_RST:** bram_rsta=1 for exactly RST_CYCLES cycles, starting at the first edge after reset release. Then go to INIT_WAIT with bram_rsta=0.
- **INIT_WAIT:** stay at least 2 cycles. Exit to RUN at the first edge where bram_rsta_busy is sampled 0 after that minimum.
- **RUN:** ready=1. It stays 1 until the next reset.
- **No grants outside RUN:** requests are ignored and held off, not dropped.

Issue and arbitration (RUN only, evaluated each edge):
- **Eligibility:** a port is eligible if req=1 and its gnt is not currently 1. This masking prevents re-granting a request still held in the gnt cycle, so a single port gets at most one grant every 2 cycles.
- **One eligible port:** grant it.
- **Both eligible:** grant the port other than the last-granted one. The pointer updates only on a grant.
- **On grant, same edge:** gnt=1 for the winner; bram_ena=1, bram_wea=we, bram_addra=addr, bram_dina=wdata (0 for reads).
- **No grant:** bram_ena=0, bram_wea=0. addra and dina hold.
- **Writes:** complete at grant; no response.
- **Reads:** push a port tag into an RD_LAT-deep shift pipe. When the tag exits, capture bram_douta into that port's rdata and pulse its rvalid.
- **Read latency:** rvalid is high exactly RD_LAT+1 cycles after the cycle in which gnt is high.
- **Ordering:** accesses take effect on the BRAM in grant order. A read granted after a write to the same address returns the new data.
- **Addresses:** used as-is. 0xFFF and 0x000 are ordinary locations; no wrap logic.
- **Reset mid-operation:** in-flight reads are discarded with no rvalid. rdata is zeroed and the init sequence reruns.
- **bram_rsta_busy in RUN:** ignored.

Decomposition:
- Shared package bus_pkg holds:
  - ADDR_W and DATA_W defaults;
  - state encodings INIT_RST, INIT_WAIT, RUN;
  - port-tag encoding (tag valid bit plus port id).
- Sub-module rr_arb2: two-input round-robin arbiter with masked requests and a pointer register. Reused by other shared slaves on the bus.

Test Plan:
1. **Init:** release reset; BRAM model holds rsta_busy=1 for 4 cycles after rsta -> bram_rsta high exactly 3 cycles. ready rises on the first edge after busy is seen low (minimum 2 cycles in INIT_WAIT). m0_req held during init gets no gnt until ready=1.
2. **Write then read:** m0 writes 0x002 <= 0xAA, then reads 0x002 -> bram_ena/wea/addra/dina = 1/1/0x002/0xAA in the gnt cycle. The read gives m0_rvalid 3 cycles after its gnt, with m0_rdata=0xAA.
3. **Simultaneous requests:** m0 writes 0x010 <= 0x55 and m1 reads 0x010, both requesting in the same cycle -> m0_gnt first, m1_gnt the next cycle, m1_rdata=0x55. m0_rvalid never pulses.
4. **Back-to-back traffic:** both ports request continuously for 8 accesses each -> grants alternate m0, m1, m0, ...; bram_ena stays 1 every cycle; no port is granted on two consecutive cycles.
5. **Boundary addresses:** write 0xFFF <= 0x3C and 0x000 <= 0xC3, read both back -> 0x3C and 0xC3 respectively, with no aliasing.
6. **Reset mid-read:** drive reset=0 one cycle after an m1 read gnt -> all outputs 0 immediately. No m1_rvalid after release; the init sequence from scenario 1 repeats.
